// File: rtl/abs_diff_eval_pkg.sv
// Shared types and width helpers for the abs_diff error-evaluation slice.
package abs_diff_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    localparam int DEF_OP_W = 2;

    function automatic int vec_w(input int op_w);
        return 2 * op_w;
    endfunction

    // One extra bit so a sweep where every vector fails still fits.
    function automatic int cnt_w(input int op_w);
        return 2 * op_w + 1;
    endfunction

    function automatic int sum_w(input int op_w);
        return 3 * op_w;
    endfunction

    localparam int VEC_W = vec_w(DEF_OP_W);
    localparam int CNT_W = cnt_w(DEF_OP_W);
    localparam int SUM_W = sum_w(DEF_OP_W);

endpackage

// File: rtl/abs_diff_exact.sv
// Combinational golden absolute-difference model: po = |a - b| with pi = {b, a}.
module abs_diff_exact #(
    parameter int OP_W = 2
) (
    input  logic [2*OP_W-1:0] pi,
    output logic [OP_W-1:0]   po
);

    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;

    assign a  = pi[OP_W-1:0];
    assign b  = pi[2*OP_W-1:OP_W];
    assign po = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/abs_diff_err_sweep.sv
// Exhaustive sweep controller: drives every vector into an approximate abs_diff
// netlist, compares against the exact model and accumulates error statistics.
module abs_diff_err_sweep
    import abs_diff_eval_pkg::*;
#(
    parameter int OP_W   = 2,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [vec_w(OP_W)-1:0]    approx_pi,
    input  logic [OP_W-1:0]           approx_po,
    output logic [cnt_w(OP_W)-1:0]    err_cnt,
    output logic [OP_W-1:0]           max_err,
    output logic [sum_w(OP_W)-1:0]    sum_err,
    output logic [vec_w(OP_W)-1:0]    first_fail,
    output logic                      first_fail_vld
);

    localparam int L_VEC_W = vec_w(OP_W);
    localparam int L_CNT_W = cnt_w(OP_W);
    localparam int L_SUM_W = sum_w(OP_W);
    localparam int SCNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SCNT_W-1:0]  SETTLE_LAST = SCNT_W'(SETTLE - 1);
    localparam logic [L_VEC_W-1:0] VEC_LAST    = '1;

    generate
        if (SETTLE < 1) begin : g_settle_chk
            $error("abs_diff_err_sweep: SETTLE must be >= 1");
        end
    endgenerate

    sweep_state_e         state_q, state_d;
    logic [L_VEC_W-1:0]   vec_q, vec_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [L_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [OP_W-1:0]      max_err_q, max_err_d;
    logic [L_SUM_W-1:0]   sum_err_q, sum_err_d;
    logic [L_VEC_W-1:0]   first_fail_q, first_fail_d;
    logic                 first_fail_vld_q, first_fail_vld_d;

    logic [OP_W-1:0]      exact_po;
    logic [OP_W-1:0]      err_dist;

    abs_diff_exact #(
        .OP_W (OP_W)
    ) u_exact (
        .pi (vec_q),
        .po (exact_po)
    );

    assign err_dist = (exact_po >= approx_po) ? (exact_po - approx_po)
                                              : (approx_po - exact_po);

    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        scnt_d           = scnt_q;
        err_cnt_d        = err_cnt_q;
        max_err_d        = max_err_q;
        sum_err_d        = sum_err_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d          = ST_DRIVE;
                    vec_d            = '0;
                    scnt_d           = '0;
                    err_cnt_d        = '0;
                    max_err_d        = '0;
                    sum_err_d        = '0;
                    first_fail_d     = '0;
                    first_fail_vld_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                // Hold the vector SETTLE cycles so the netlist output is stable at CMP.
                if (scnt_q == SETTLE_LAST) begin
                    scnt_d  = '0;
                    state_d = ST_CMP;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            ST_CMP: begin
                if (err_dist != '0) begin
                    err_cnt_d = err_cnt_q + L_CNT_W'(1);
                    if (!first_fail_vld_q) begin
                        first_fail_d     = vec_q;
                        first_fail_vld_d = 1'b1;
                    end
                end
                if (err_dist > max_err_q) begin
                    max_err_d = err_dist;
                end
                sum_err_d = sum_err_q + L_SUM_W'(err_dist);
                // Natural wrap leaves approx_pi at zero once the sweep ends.
                vec_d   = vec_q + L_VEC_W'(1);
                state_d = (vec_q == VEC_LAST) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            vec_q            <= '0;
            scnt_q           <= '0;
            err_cnt_q        <= '0;
            max_err_q        <= '0;
            sum_err_q        <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            scnt_q           <= scnt_d;
            err_cnt_q        <= err_cnt_d;
            max_err_q        <= max_err_d;
            sum_err_q        <= sum_err_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
        end
    end

    assign busy           = (state_q == ST_DRIVE) || (state_q == ST_CMP);
    assign done           = (state_q == ST_DONE);
    assign approx_pi      = vec_q;
    assign err_cnt        = err_cnt_q;
    assign max_err        = max_err_q;
    assign sum_err        = sum_err_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Directed bench for abs_diff_err_sweep with SETTLE=1 and SETTLE=3 instances.
module tb_abs_diff_err_sweep;

    localparam int M_LOOP  = 0;
    localparam int M_STUCK = 1;
    localparam int M_FAULT = 2;

    logic       clk;
    logic       rst_n;
    logic       start1, start3;
    logic       busy1, busy3, done1, done3;
    logic [3:0] pi1, pi3;
    logic [1:0] po1, po3, ex1, ex3;
    logic [4:0] ec1, ec3;
    logic [1:0] mx1, mx3;
    logic [5:0] se1, se3;
    logic [3:0] ff1, ff3;
    logic       fv1, fv3;
    int         mode1, mode3;

    int n_chk  = 0;
    int n_pass = 0;

    abs_diff_err_sweep #(.OP_W(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .approx_pi(pi1), .approx_po(po1), .err_cnt(ec1), .max_err(mx1),
        .sum_err(se1), .first_fail(ff1), .first_fail_vld(fv1)
    );

    abs_diff_err_sweep #(.OP_W(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .approx_pi(pi3), .approx_po(po3), .err_cnt(ec3), .max_err(mx3),
        .sum_err(se3), .first_fail(ff3), .first_fail_vld(fv3)
    );

    abs_diff_exact #(.OP_W(2)) ref1 (.pi(pi1), .po(ex1));
    abs_diff_exact #(.OP_W(2)) ref3 (.pi(pi3), .po(ex3));

    function automatic logic [1:0] approx_model(input int m, input logic [3:0] pi,
                                                input logic [1:0] ex);
        case (m)
            M_STUCK: return 2'd0;
            M_FAULT: return (pi == 4'b1011) ? 2'd3 : ex;
            default: return ex;
        endcase
    endfunction

    always_comb begin
        po1 = approx_model(mode1, pi1, ex1);
        po3 = approx_model(mode3, pi3, ex3);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse start on the chosen instance and run to its done pulse.
    task automatic run_sweep(input bit sel3, output int bc, output bit got_done);
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        bc = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            if (sel3 ? busy3 : busy1) bc++;
            if (sel3 ? done3 : done1) got_done = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic chk_res1(input string tag, input int ec, input int mx, input int se,
                            input int ff, input int fv);
        chk({tag, "_err_cnt"}, 32'(ec1), 32'(ec));
        chk({tag, "_max_err"}, 32'(mx1), 32'(mx));
        chk({tag, "_sum_err"}, 32'(se1), 32'(se));
        chk({tag, "_first_fail"}, 32'(ff1), 32'(ff));
        chk({tag, "_first_fail_vld"}, 32'(fv1), 32'(fv));
    endtask

    initial begin
        int  bc, cnt, t0, t1, t2, nd, run, rmin, rmax;
        bit  gd, found;
        logic [3:0] prev;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = M_LOOP;
        mode3  = M_STUCK;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pi", 32'(pi1), 32'd0);
        chk_res1("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback: exact vs exact.
        run_sweep(1'b0, bc, gd);
        chk("loop_busy_cycles", 32'(bc), 32'd32);
        chk("loop_pi_at_done", 32'(pi1), 32'd0);
        chk_res1("loop", 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("loop_done_one_cycle", 32'(done1), 32'd0);

        // Stuck-at-0 approximate output.
        mode1 = M_STUCK;
        run_sweep(1'b0, bc, gd);
        chk("stuck_busy_cycles", 32'(bc), 32'd32);
        chk_res1("stuck", 12, 3, 20, 1, 1);
        repeat (5) @(negedge clk);
        chk("stuck_hold_err_cnt", 32'(ec1), 32'd12);
        chk("stuck_hold_sum_err", 32'(se1), 32'd20);

        // Single faulty vector.
        mode1 = M_FAULT;
        run_sweep(1'b0, bc, gd);
        chk_res1("fault", 1, 2, 2, 11, 1);

        // SETTLE=3 instance: measure how long each vector is held.
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        bc = 0; gd = 1'b0; run = 0; rmin = 1000; rmax = 0; prev = pi3;
        for (int i = 0; i < 200 && !gd; i++) begin
            if (busy3) begin
                bc++;
                if (run != 0 && pi3 != prev) begin
                    if (run < rmin) rmin = run;
                    if (run > rmax) rmax = run;
                    run = 0;
                end
                prev = pi3;
                run++;
            end
            if (done3) gd = 1'b1;
            else @(negedge clk);
        end
        if (run < rmin) rmin = run;
        if (run > rmax) rmax = run;
        chk("s3_done_seen", 32'(gd), 32'd1);
        chk("s3_busy_cycles", 32'(bc), 32'd64);
        chk("s3_hold_min", 32'(rmin), 32'd4);
        chk("s3_hold_max", 32'(rmax), 32'd4);
        chk("s3_err_cnt", 32'(ec3), 32'd12);
        chk("s3_max_err", 32'(mx3), 32'd3);
        chk("s3_sum_err", 32'(se3), 32'd20);
        chk("s3_first_fail", 32'(ff3), 32'd1);
        chk("s3_first_fail_vld", 32'(fv3), 32'd1);

        // Reset while vector 7 is on the bus.
        mode1 = M_STUCK;
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pi1 == 4'b0111) found = 1'b1;
            else @(negedge clk);
        end
        chk("rstmid_reach_vec7", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy1), 32'd0);
        chk("rstmid_done", 32'(done1), 32'd0);
        chk("rstmid_pi", 32'(pi1), 32'd0);
        chk_res1("rstmid", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) nd++;
        end
        chk("rstmid_no_done", 32'(nd), 32'd0);
        run_sweep(1'b0, bc, gd);
        chk("rstmid_busy_cycles", 32'(bc), 32'd32);
        chk_res1("rstmid_rerun", 12, 3, 20, 1, 1);

        // Extra start pulses while busy must be ignored.
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nd = 0; bc = 0;
        for (int i = 0; i < 60; i++) begin
            start1 = (i == 4 || i == 11 || i == 12 || i == 20) ? 1'b1 : 1'b0;
            if (busy1) bc++;
            if (done1) nd++;
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("extra_start_dones", 32'(nd), 32'd1);
        chk("extra_start_busy", 32'(bc), 32'd32);

        // Start held high: back-to-back sweeps.
        mode1 = M_FAULT;
        start1 = 1'b1;
        nd = 0; t0 = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 150 && nd < 3; i++) begin
            @(negedge clk);
            if (done1) begin
                if (nd == 0) t0 = i;
                else if (nd == 1) t1 = i;
                else t2 = i;
                chk("held_err_cnt", 32'(ec1), 32'd1);
                chk("held_sum_err", 32'(se1), 32'd2);
                chk("held_first_fail", 32'(ff1), 32'd11);
                nd++;
            end
        end
        start1 = 1'b0;
        chk("held_done_count", 32'(nd), 32'd3);
        chk("held_period_1", 32'(t1 - t0), 32'd34);
        chk("held_period_2", 32'(t2 - t1), 32'd34);
        repeat (40) @(negedge clk);
        chk("held_idle_after", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
